// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals for alu_arbiter.
// slave = arbiter side; master = requesters, external ALU and response consumer.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic [3:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic [3:0]  req1_op;

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_y;
    logic        alu_z;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_y;
    logic        rsp_z;
    logic        rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_y, alu_z, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_y, rsp_z, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_y, alu_z, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_y, rsp_z, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port sequencing arbiter in front of the shared 64-bit execute ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
//
// Handshakes: a request transfers on a cycle where reqN_valid && reqN_ready (ready is only
// ever high in IDLE, for the granted port); a response transfers on rsp_valid && rsp_ready,
// and all rsp fields hold steady while rsp_valid is high and rsp_ready is low.
module alu_arbiter (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] a_r;
    logic [63:0] b_r;
    logic [3:0]  op_r;
    logic        id_r;

    logic [63:0] y_r;
    logic        z_r;
    logic        err_r;
    logic        rid_r;

    logic        grant0;
    logic        grant1;
    logic        accept;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b1100, 4'b0111: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
    endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid && !bus.req0_valid;
    end
`else
    // last_id is the port granted most recently; resets to 1 so port 0 wins the first contest.
    logic last_id;

    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_id);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_id <= 1'b1;
        end else if (accept) begin
            last_id <= grant1;
        end
    end
`endif

    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                // A grant during reset would be discarded, so ready stays low.
                if (!rst && (grant0 || grant1)) begin
                    accept         = 1'b1;
                    bus.req0_ready = grant0;
                    bus.req1_ready = grant1;
                    state_nxt      = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= 64'd0;
            b_r  <= 64'd0;
            op_r <= 4'd0;
            id_r <= 1'b0;
        end else if (accept) begin
            a_r  <= grant1 ? bus.req1_a  : bus.req0_a;
            b_r  <= grant1 ? bus.req1_b  : bus.req0_b;
            op_r <= grant1 ? bus.req1_op : bus.req0_op;
            id_r <= grant1;
        end
    end

    // For an illegal op the ALU output is meaningless; report a fixed error result instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r   <= 64'd0;
            z_r   <= 1'b0;
            err_r <= 1'b0;
            rid_r <= 1'b0;
        end else if (state == EXEC) begin
            rid_r <= id_r;
            if (op_legal(op_r)) begin
                y_r   <= bus.alu_y;
                z_r   <= bus.alu_z;
                err_r <= 1'b0;
            end else begin
                y_r   <= 64'd0;
                z_r   <= 1'b1;
                err_r <= 1'b1;
            end
        end
    end

    assign bus.alu_a   = a_r;
    assign bus.alu_b   = b_r;
    assign bus.alu_op  = op_r;
    assign bus.rsp_id  = rid_r;
    assign bus.rsp_y   = y_r;
    assign bus.rsp_z   = z_r;
    assign bus.rsp_err = err_r;
    assign dbg_state   = state;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1100: return ~(a | b);
            4'b0111: return b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    endfunction

    // External ALU: correct for legal ops, junk for illegal ones.
    logic [63:0] garbage = 64'h0;
    logic [63:0] alu_tmp;
    always @(posedge clk) garbage <= {$urandom, $urandom};
    always_comb begin
        alu_tmp = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
        if (ref_legal(bus.alu_op)) begin
            bus.alu_y = alu_tmp;
            bus.alu_z = (alu_tmp == 64'd0);
        end else begin
            bus.alu_y = garbage;
            bus.alu_z = garbage[0];
        end
    end

    // Reference model: one op in flight; response visible from two cycles after accept.
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_last = 1'b1;
    logic [63:0] m_a, m_b;
    logic [3:0]  m_op;
    bit          m_id;
    int          grant_log[$];
    bit          g, any_v, e_acc, e_vld;
    logic [63:0] e_y;

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_busy) m_age++;
            any_v = bus.req0_valid || bus.req1_valid;
            g     = (bus.req0_valid && bus.req1_valid) ? (FIXED ? 1'b0 : !m_last) : bus.req1_valid;
            e_acc = !m_busy && !rst && any_v;
            e_vld = m_busy && (m_age >= 2);
            chk("req0_ready", bus.req0_ready, e_acc && !g);
            chk("req1_ready", bus.req1_ready, e_acc && g);
            chk("rsp_valid", bus.rsp_valid, e_vld);
            if (m_busy && m_age >= 1) begin
                chk("alu_a", bus.alu_a, m_a);
                chk("alu_b", bus.alu_b, m_b);
                chk("alu_op", bus.alu_op, m_op);
            end
            if (e_vld) begin
                e_y = ref_legal(m_op) ? ref_alu(m_op, m_a, m_b) : 64'd0;
                chk("rsp_id", bus.rsp_id, m_id);
                chk("rsp_y", bus.rsp_y, e_y);
                chk("rsp_z", bus.rsp_z, ref_legal(m_op) ? (e_y == 64'd0) : 1'b1);
                chk("rsp_err", bus.rsp_err, !ref_legal(m_op));
            end
            if (rst) begin
                m_busy = 1'b0;
                m_last = 1'b1;
            end else if (e_acc) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = g;
                m_last = g;
                m_a    = g ? bus.req1_a  : bus.req0_a;
                m_b    = g ? bus.req1_b  : bus.req0_b;
                m_op   = g ? bus.req1_op : bus.req0_op;
                grant_log.push_back(int'(g));
            end else if (e_vld && bus.rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit port, input bit v, input logic [3:0] op,
                              input logic [63:0] a, input logic [63:0] b);
        if (port) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic check_zero(input string nm);
        @(negedge clk);
        chk({nm, "_ready0"}, bus.req0_ready, 0);
        chk({nm, "_ready1"}, bus.req1_ready, 0);
        chk({nm, "_valid"}, bus.rsp_valid, 0);
        chk({nm, "_id"}, bus.rsp_id, 0);
        chk({nm, "_y"}, bus.rsp_y, 0);
        chk({nm, "_z"}, bus.rsp_z, 0);
        chk({nm, "_err"}, bus.rsp_err, 0);
        chk({nm, "_alu_a"}, bus.alu_a, 0);
        chk({nm, "_alu_b"}, bus.alu_b, 0);
        chk({nm, "_alu_op"}, bus.alu_op, 0);
    endtask

    // Issue one op on an idle DUT, expect ready at once, response two cycles later,
    // hold it for `hold` cycles under backpressure, then consume it.
    task automatic do_op(input string nm, input bit port, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b, input int hold,
                         input logic [63:0] ey, input bit ez, input bit eerr);
        int lat;
        bus.rsp_ready = (hold == 0);
        drive_port(port, 1'b1, op, a, b);
        @(negedge clk);
        chk({nm, "_ready"}, port ? bus.req1_ready : bus.req0_ready, 1);
        step();
        drive_port(port, 1'b0, 4'd0, 64'd0, 64'd0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 10);
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_id"}, bus.rsp_id, port);
        chk({nm, "_y"}, bus.rsp_y, ey);
        chk({nm, "_z"}, bus.rsp_z, ez);
        chk({nm, "_err"}, bus.rsp_err, eerr);
        for (int i = 0; i < hold; i++) begin
            step();
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            @(negedge clk);
            chk({nm, "_held_y"}, bus.rsp_y, ey);
            chk({nm, "_held_rdy"}, {bus.req0_ready, bus.req1_ready}, 0);
        end
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (hold != 0) begin
            bus.rsp_ready = 1'b1;
            step();
        end
        bus.rsp_ready = 1'b0;
    endtask

    logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'd1;
            3:       return 64'($urandom_range(0, 255));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
        return legal_ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        bus.rsp_ready = 1'b0;
        drive_port(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
        drive_port(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        check_zero("reset");
        step();

        do_op("add_5_7", 1'b0, 4'b0010, 64'd5, 64'd7, 0, 64'd12, 1'b0, 1'b0);
        do_op("sub_eq", 1'b1, 4'b0110, 64'h1234, 64'h1234, 0, 64'd0, 1'b1, 1'b0);
        do_op("sub_0_1", 1'b1, 4'b0110, 64'd0, 64'd1, 0, {64{1'b1}}, 1'b0, 1'b0);
        do_op("nor_bp", 1'b0, 4'b1100, 64'd0, 64'd0, 10, {64{1'b1}}, 1'b0, 1'b0);
        do_op("illegal", 1'b1, 4'b0101, 64'd3, 64'd9, 0, 64'd0, 1'b1, 1'b1);
        do_op("pass_b", 1'b0, 4'b0111, 64'hdead, 64'hbeef, 0, 64'hbeef, 1'b0, 1'b0);

        // Reset while the op is in EXEC: it must vanish without a response.
        drive_port(1'b1, 1'b1, 4'b0010, 64'd1, 64'd2);
        bus.rsp_ready = 1'b1;
        step();
        drive_port(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("rst_exec");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_exec_no_rsp", bus.rsp_valid, 0);
        end

        // Contention straight after reset.
        grant_log.delete();
        step();
        for (int i = 0; i < 15; i++) begin
            drive_port(1'b0, 1'b1, 4'b0010, rand_val(), rand_val());
            drive_port(1'b1, 1'b1, 4'b0010, rand_val(), rand_val());
            step();
        end
        drive_port(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
        drive_port(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
        chk("contend_count", 64'(grant_log.size() >= 4), 1);
        if (grant_log.size() >= 4) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("contend_g0", grant_log[0], 0);
            chk("contend_g1", grant_log[1], 0);
            chk("contend_g2", grant_log[2], 0);
            chk("contend_g3", grant_log[3], 0);
`else
            chk("contend_g0", grant_log[0], 0);
            chk("contend_g1", grant_log[1], 1);
            chk("contend_g2", grant_log[2], 0);
            chk("contend_g3", grant_log[3], 1);
`endif
        end
        repeat (4) step();

        for (int i = 0; i < 1500; i++) begin
            drive_port(1'b0, $urandom_range(0, 2) != 0, rand_op(), rand_val(), rand_val());
            drive_port(1'b1, $urandom_range(0, 2) != 0, rand_op(), rand_val(), rand_val());
            bus.rsp_ready = $urandom_range(0, 2) != 0;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        drive_port(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
        drive_port(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
        bus.rsp_ready = 1'b1;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
